// File: rtl/reg_scoreboard.sv
// Scoreboard of outstanding long-latency register writes; gates issue on RAW/WAW hazards
// the bypass network cannot cover. Optional macro SB_WB_BYPASS_EN lets same-cycle writebacks satisfy a source.
module reg_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int TOT_MAX = 8,
    parameter int TOT_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             issue_valid_i,
    input  logic [4:0]       issue_rs1_i,
    input  logic             issue_rs1_used_i,
    input  logic [4:0]       issue_rs2_i,
    input  logic             issue_rs2_used_i,
    input  logic [4:0]       issue_rd_i,
    input  logic             issue_long_i,
    input  logic             flush_i,
    output logic             issue_ready_o,
    output logic             raw_stall_o,
    output logic             waw_stall_o,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    output logic [31:0]      busy_mask_o,
    output logic [TOT_W-1:0] pend_total_o,
    output logic             err_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_LIM = TOT_W'(TOT_MAX);

    logic [CNT_W-1:0] w_cnt [32];
    logic [TOT_W-1:0] r_total;
    logic             r_err;

    logic w_rs1_pend;
    logic w_rs2_pend;
    logic w_rs1_byp;
    logic w_rs2_byp;
    logic w_wb_live;
    logic w_wb_hit;
    logic w_wb_err;
    logic w_fire;

`ifdef SB_WB_BYPASS_EN
    // Last outstanding write landing this cycle reaches the consumer via register-file write-through.
    assign w_rs1_byp = (w_cnt[issue_rs1_i] == CNT_W'(1)) && wb_valid_i && (wb_rd_i == issue_rs1_i);
    assign w_rs2_byp = (w_cnt[issue_rs2_i] == CNT_W'(1)) && wb_valid_i && (wb_rd_i == issue_rs2_i);
`else
    assign w_rs1_byp = 1'b0;
    assign w_rs2_byp = 1'b0;
`endif

    assign w_rs1_pend = issue_rs1_used_i && (issue_rs1_i != 5'd0) &&
                        (w_cnt[issue_rs1_i] != '0) && !w_rs1_byp;
    assign w_rs2_pend = issue_rs2_used_i && (issue_rs2_i != 5'd0) &&
                        (w_cnt[issue_rs2_i] != '0) && !w_rs2_byp;

    assign raw_stall_o   = issue_valid_i && (w_rs1_pend || w_rs2_pend);
    assign waw_stall_o   = issue_valid_i && issue_long_i && (issue_rd_i != 5'd0) &&
                           ((w_cnt[issue_rd_i] == CNT_MAX) || (r_total == TOT_LIM));
    assign issue_ready_o = !raw_stall_o && !waw_stall_o;

    assign w_fire    = issue_valid_i && issue_ready_o && !flush_i && issue_long_i &&
                       (issue_rd_i != 5'd0);
    assign w_wb_live = wb_valid_i && (wb_rd_i != 5'd0);
    assign w_wb_hit  = w_wb_live && (w_cnt[wb_rd_i] != '0);
    assign w_wb_err  = w_wb_live && (w_cnt[wb_rd_i] == '0);

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;

            assign w_inc = w_fire && (issue_rd_i == 5'(gi));
            assign w_dec = w_wb_hit && (wb_rd_i == 5'(gi));

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (w_inc && !w_dec) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end else if (w_dec && !w_inc) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end

            assign w_cnt[gi]       = r_cnt;
            assign busy_mask_o[gi] = (r_cnt != '0);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_total <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_fire && !w_wb_hit) begin
                r_total <= r_total + TOT_W'(1);
            end else if (w_wb_hit && !w_fire) begin
                r_total <= r_total - TOT_W'(1);
            end
            if (w_wb_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pend_total_o = r_total;
    assign err_o        = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: inputs change on the falling edge, combinational
// outputs are checked 1ns later, registered state one cycle after the causing edge.
module tb_reg_scoreboard;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rs1_i;
    logic        issue_rs1_used_i;
    logic [4:0]  issue_rs2_i;
    logic        issue_rs2_used_i;
    logic [4:0]  issue_rd_i;
    logic        issue_long_i;
    logic        flush_i;
    logic        issue_ready_o;
    logic        raw_stall_o;
    logic        waw_stall_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] busy_mask_o;
    logic [3:0]  pend_total_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(.CNT_W(2), .TOT_MAX(8), .TOT_W(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .issue_valid_i    (issue_valid_i),
        .issue_rs1_i      (issue_rs1_i),
        .issue_rs1_used_i (issue_rs1_used_i),
        .issue_rs2_i      (issue_rs2_i),
        .issue_rs2_used_i (issue_rs2_used_i),
        .issue_rd_i       (issue_rd_i),
        .issue_long_i     (issue_long_i),
        .flush_i          (flush_i),
        .issue_ready_o    (issue_ready_o),
        .raw_stall_o      (raw_stall_o),
        .waw_stall_o      (waw_stall_o),
        .wb_valid_i       (wb_valid_i),
        .wb_rd_i          (wb_rd_i),
        .busy_mask_o      (busy_mask_o),
        .pend_total_o     (pend_total_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rs1, input logic u1,
                             input logic [4:0] rs2, input logic u2,
                             input logic [4:0] rd, input logic lng, input logic fl);
        issue_valid_i    = v;
        issue_rs1_i      = rs1;
        issue_rs1_used_i = u1;
        issue_rs2_i      = rs2;
        issue_rs2_used_i = u2;
        issue_rd_i       = rd;
        issue_long_i     = lng;
        flush_i          = fl;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid_i = v;
        wb_rd_i    = rd;
    endtask

    task automatic idle();
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0);
    endtask

    // Present a long op to rd, confirm it is accepted, advance one cycle.
    task automatic issue_long(input logic [4:0] rd, input string tag);
        idle();
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b0);
        #1 chk(tag, 32'(issue_ready_o), 32'd1);
        @(negedge clk_i);
    endtask

    task automatic wb_only(input logic [4:0] rd);
        idle();
        set_wb(1'b1, rd);
        @(negedge clk_i);
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state
        #1;
        chk("rst_busy", busy_mask_o, 32'h0);
        chk("rst_total", 32'(pend_total_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        set_issue(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b0, 1'b0);
        #1 chk("rst_ready", 32'(issue_ready_o), 32'd1);
        @(negedge clk_i);

        // Test 1: long write to x5, then RAW on rs1 and rs2
        issue_long(5'd5, "t1_issue_ready");
        idle();
        set_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("t1_busy", busy_mask_o, 32'h0000_0020);
        chk("t1_total", 32'(pend_total_o), 32'd1);
        chk("t1_raw", 32'(raw_stall_o), 32'd1);
        chk("t1_ready", 32'(issue_ready_o), 32'd0);
        set_issue(1'b1, 5'd0, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 chk("t1_raw_rs2", 32'(raw_stall_o), 32'd1);
        set_issue(1'b1, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 chk("t1_rs2_unused", 32'(raw_stall_o), 32'd0);
        set_issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

        // Test 2: writeback of x5 while rs1=5 waits
        set_wb(1'b1, 5'd5);
`ifdef SB_WB_BYPASS_EN
        #1;
        chk("t2_wbcyc_raw", 32'(raw_stall_o), 32'd0);
        chk("t2_wbcyc_ready", 32'(issue_ready_o), 32'd1);
`else
        #1;
        chk("t2_wbcyc_raw", 32'(raw_stall_o), 32'd1);
        chk("t2_wbcyc_ready", 32'(issue_ready_o), 32'd0);
`endif
        @(negedge clk_i);
        set_wb(1'b0, 5'd0);
        #1;
        chk("t2_next_ready", 32'(issue_ready_o), 32'd1);
        chk("t2_next_busy", busy_mask_o, 32'h0);
        chk("t2_next_total", 32'(pend_total_o), 32'd0);
        @(negedge clk_i);

        // Test 3: per-register counter saturation on x7
        issue_long(5'd7, "t3_i1");
        issue_long(5'd7, "t3_i2");
        issue_long(5'd7, "t3_i3");
        idle();
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        #1;
        chk("t3_busy", busy_mask_o, 32'h0000_0080);
        chk("t3_total", 32'(pend_total_o), 32'd3);
        chk("t3_waw", 32'(waw_stall_o), 32'd1);
        chk("t3_ready", 32'(issue_ready_o), 32'd0);
        set_wb(1'b1, 5'd7);
        #1 chk("t3_waw_wbcyc", 32'(waw_stall_o), 32'd1);
        @(negedge clk_i);
        set_wb(1'b0, 5'd0);
        #1;
        chk("t3_total_after_wb", 32'(pend_total_o), 32'd2);
        chk("t3_waw_next", 32'(waw_stall_o), 32'd0);
        chk("t3_ready_next", 32'(issue_ready_o), 32'd1);
        @(negedge clk_i);
        idle();
        #1 chk("t3_total_refill", 32'(pend_total_o), 32'd3);
        wb_only(5'd7);
        wb_only(5'd7);
        wb_only(5'd7);
        #1;
        chk("t3_drain_total", 32'(pend_total_o), 32'd0);
        chk("t3_drain_err", 32'(err_o), 32'd0);

        // Test 4: global TOT_MAX limit
        for (int r = 1; r <= 8; r++) issue_long(5'(r), "t4_fill");
        idle();
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        #1;
        chk("t4_total", 32'(pend_total_o), 32'd8);
        chk("t4_busy", busy_mask_o, 32'h0000_01FE);
        chk("t4_waw", 32'(waw_stall_o), 32'd1);
        @(negedge clk_i);
        #1 chk("t4_waw_hold", 32'(waw_stall_o), 32'd1);
        set_wb(1'b1, 5'd1);
        #1;
        chk("t4_waw_wbcyc", 32'(waw_stall_o), 32'd1);
        chk("t4_ready_wbcyc", 32'(issue_ready_o), 32'd0);
        @(negedge clk_i);
        set_wb(1'b0, 5'd0);
        #1;
        chk("t4_total_after_wb", 32'(pend_total_o), 32'd7);
        chk("t4_ready_next", 32'(issue_ready_o), 32'd1);
        @(negedge clk_i);
        idle();
        #1;
        chk("t4_total_refill", 32'(pend_total_o), 32'd8);
        chk("t4_busy_refill", busy_mask_o, 32'h0000_03FC);
        wb_only(5'd2);
        for (int r = 4; r <= 9; r++) wb_only(5'(r));
        #1;
        chk("t4_drain_total", 32'(pend_total_o), 32'd1);
        chk("t4_drain_busy", busy_mask_o, 32'h0000_0008);

        // Test 5: simultaneous fire and writeback to x3
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        set_wb(1'b1, 5'd3);
        #1 chk("t5_ready", 32'(issue_ready_o), 32'd1);
        @(negedge clk_i);
        idle();
        #1;
        chk("t5_busy", busy_mask_o, 32'h0000_0008);
        chk("t5_total", 32'(pend_total_o), 32'd1);
        // Fire to x10 while x3 retires: both counters move, total stays
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        set_wb(1'b1, 5'd3);
        @(negedge clk_i);
        idle();
        #1;
        chk("t5_diff_busy", busy_mask_o, 32'h0000_0400);
        chk("t5_diff_total", 32'(pend_total_o), 32'd1);
        wb_only(5'd10);

        // Test 6: x0 handling, flush, error flag
        wb_only(5'd0);
        #1;
        chk("t6_wb0_err", 32'(err_o), 32'd0);
        chk("t6_wb0_total", 32'(pend_total_o), 32'd0);
        set_issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        chk("t6_rd0_ready", 32'(issue_ready_o), 32'd1);
        chk("t6_rd0_waw", 32'(waw_stall_o), 32'd0);
        @(negedge clk_i);
        idle();
        #1;
        chk("t6_rd0_total", 32'(pend_total_o), 32'd0);
        chk("t6_rd0_busy", busy_mask_o, 32'h0);
        set_issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        #1 chk("t6_flush_ready", 32'(issue_ready_o), 32'd1);
        @(negedge clk_i);
        idle();
        #1;
        chk("t6_flush_total", 32'(pend_total_o), 32'd0);
        chk("t6_flush_busy", busy_mask_o, 32'h0);
        wb_only(5'd12);
        #1;
        chk("t6_err_set", 32'(err_o), 32'd1);
        chk("t6_err_total", 32'(pend_total_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        #1 chk("t6_err_held", 32'(err_o), 32'd1);

        // Reset mid-operation clears everything
        issue_long(5'd6, "t7_issue");
        #1 chk("t7_pre_total", 32'(pend_total_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("t7_total", 32'(pend_total_o), 32'd0);
        chk("t7_busy", busy_mask_o, 32'h0);
        chk("t7_err", 32'(err_o), 32'd0);
        wb_only(5'd6);
        #1 chk("t7_stale_wb_err", 32'(err_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Producer-side companion to operand forwarding. It tracks architectural registers with outstanding long-latency writes (loads, mul/div) from issue until writeback. It gates instruction issue on RAW and WAW hazards that the EX/MEM and MEM/WB bypass paths cannot cover. It sits between decode and the issue/EX stage, and takes writeback notifications from the WB stage.

Parameters:
CNT_W, 2, width of the per-register pending counter; maximum pending writes per register = 2^CNT_W-1
TOT_MAX, 8, maximum total outstanding long-latency writes across all registers
TOT_W, 4, width of pend_total_o; must hold TOT_MAX

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  synchronous reset, active-high
issue_valid_i  input  1  decode presents an instruction this cycle
issue_rs1_i  input  5  source register 1
issue_rs1_used_i  input  1  instruction reads rs1
issue_rs2_i  input  5  source register 2
issue_rs2_used_i  input  1  instruction reads rs2
issue_rd_i  input  5  destination register
issue_long_i  input  1  instruction writes rd via a long-latency path (tracked)
flush_i  input  1  kill the instruction currently at issue
issue_ready_o  output  1  instruction may issue this cycle
raw_stall_o  output  1  blocked by a pending source
waw_stall_o  output  1  blocked by rd counter saturation or TOT_MAX
wb_valid_i  input  1  long-latency writeback completes this cycle
wb_rd_i  input  5  writeback destination
busy_mask_o  output  32  bit n = register n has a nonzero pending count
pend_total_o  output  TOT_W  total outstanding tracked writes
err_o  output  1  sticky: writeback to a register with count 0

Behaviour:
- Reset (synchronous): all counters = 0; busy_mask_o = 0; pend_total_o = 0; err_o = 0. issue_ready_o then equals 1 whenever inputs present no hazard.
- Register x0 is never tracked:
  - Issue with rd=0 does not increment any counter.
  - Sources equal to 0 never stall.
  - Writeback with rd=0 is ignored and does not raise err_o.
- raw_stall_o = issue_valid_i & ((rs1_used & cnt[rs1]!=0) | (rs2_used & cnt[rs2]!=0)), with x0 excluded.
- waw_stall_o = issue_valid_i & issue_long_i & rd!=0 & (cnt[rd]==2^CNT_W-1 | pend_total==TOT_MAX).
- issue_ready_o = ~raw_stall_o & ~waw_stall_o. It is combinational and has no dependency on flush_i.
- fire = issue_valid_i & issue_ready_o & ~flush_i & issue_long_i & rd!=0. On fire, cnt[rd] and total each increment at the next rising edge.
- Short-latency instructions (issue_long_i=0) are never tracked. The forwarding network covers them.
- On wb_valid_i with cnt[wb_rd]!=0: cnt[wb_rd] and total each decrement at the next edge.
- On wb_valid_i with cnt[wb_rd]==0: counters are unchanged and err_o is set to 1. err_o stays set until reset.
- Simultaneous fire and writeback to the same rd: cnt unchanged, total unchanged.
- Simultaneous fire and writeback to different registers: both counters update, total unchanged.
- A writeback that relieves a full TOT_MAX condition does not free issue in the same cycle. The issuing instruction sees ready only on the next cycle.
- busy_mask_o and pend_total_o are derived from registered state. They reflect an update one cycle after the causing edge inputs.
- flush_i suppresses only the current fire. In-flight tracked writes always reach writeback and decrement normally.
- Reset mid-operation clears all state. The pipeline must be reset together with this block, and any writeback arriving after reset for a pre-reset issue sets err_o.

Optional Feature:
SB_WB_BYPASS_EN
- Defined: a source with cnt==1 whose writeback occurs in the same cycle (wb_valid_i & wb_rd_i==rs) does not raise raw_stall_o. The register file write-through supplies the value.
- Undefined: any nonzero count stalls. The consumer issues one cycle after the writeback.
- WAW and TOT_MAX rules are identical in both builds.

Test Plan:
1. Reset, then issue long with rd=5 -> next cycle busy_mask_o=0x00000020 and pend_total_o=1. Issue rs1=5 -> raw_stall_o=1, issue_ready_o=0.
2. Continuing from 1, wb_valid_i with wb_rd_i=5 and rs1=5 presented:
   - Without the macro: stall that cycle; ready=1 the next cycle, busy_mask_o=0.
   - With SB_WB_BYPASS_EN: ready=1 in the same cycle.
3. Issue long with rd=7 three times (CNT_W=2) -> cnt=3. A fourth attempt -> waw_stall_o=1. One wb to rd=7 -> issue accepted the next cycle.
4. Issue 8 long ops to distinct rd=1..8 -> pend_total_o=8. A ninth to rd=9 -> waw_stall_o=1 until any wb.
5. Same cycle: fire with rd=3 (cnt=1) and wb to rd=3 -> cnt stays 1, busy bit 3 stays 1, pend_total_o unchanged.
6. wb to rd=12 with cnt 0 -> err_o=1 and held. wb to rd=0 -> no change, err_o not raised. Issue long with rd=0 -> pend_total_o unchanged. flush_i with a valid long issue -> no counter change.
